// File: rtl/mips_multi.sv
// mips_multi: multicycle MIPS integer core with one shared
// instruction/data port and a ready handshake for wait states.
module mips_multi #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          RF_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_ready,
  output logic [31:0]       pc_out,
  output logic              halted
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_MEM_ADR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  if (RF_DEPTH != 32) begin : g_bad_depth
    $error("mips_multi: RF_DEPTH must be 32");
  end

  state_t      state;
  state_t      dec_next;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] alu_out;
  logic [31:0] rf [RF_DEPTH];

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] simm;
  logic [31:0] boff;
  logic [31:0] jtgt;
  logic [31:0] ea;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] r_res;
  logic        r_ok;
  logic        br_take;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        unused_shamt;

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign simm   = {{16{ir[15]}}, ir[15:0]};
  assign boff   = {simm[29:0], 2'b00};
  assign jtgt   = {pc[31:28], ir[25:0], 2'b00};
  assign ea     = a + simm;
  assign pc_out = pc;

  assign unused_shamt = ^ir[10:6];

  // Register 0 is hardwired; its storage is never read.
  assign rs_val = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : rf[rt];

  assign br_take = (op == OP_BEQ) ? (a == b) : (a != b);

  always_comb begin
    dec_next = S_HALT;
    unique case (1'b1)
      op == OP_R:                 dec_next = S_EXEC_R;
      op == OP_LW, op == OP_SW:   dec_next = S_MEM_ADR;
      op == OP_ADDI:              dec_next = S_EXEC_I;
      op == OP_BEQ, op == OP_BNE: dec_next = S_BRANCH;
      op == OP_J:                 dec_next = S_JUMP;
      default:                    dec_next = S_HALT;
    endcase
  end

  always_comb begin
    r_res = 32'd0;
    r_ok  = 1'b1;
    unique case (funct)
      F_ADD:   r_res = a + b;
      F_SUB:   r_res = a - b;
      F_AND:   r_res = a & b;
      F_OR:    r_res = a | b;
      F_SLT:   r_res = {31'd0, $signed(a) < $signed(b)};
      default: r_ok  = 1'b0;
    endcase
  end

  assign rf_we = reset && (state == S_WB_R ||
                           state == S_WB_I ||
                           state == S_WB_MEM);
  assign rf_wa = (state == S_WB_R) ? rd : rt;
  assign rf_wd = (state == S_WB_MEM) ? mdr : alu_out;

  always_ff @(posedge clk) begin
    if (rf_we && rf_wa != 5'd0) begin
      rf[rf_wa] <= rf_wd;
    end
  end

  // Request outputs are set on entry to each memory state so they
  // are registered and stay put until mem_ready completes them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= 32'd0;
      mdr       <= 32'd0;
      a         <= 32'd0;
      b         <= 32'd0;
      alu_out   <= 32'd0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      halted    <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (!mem_read) begin
            mem_read <= 1'b1;
            mem_addr <= pc[ADDR_W-1:0];
          end else if (mem_ready) begin
            ir       <= mem_rdata;
            pc       <= pc + 32'd4;
            mem_read <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          a       <= rs_val;
          b       <= rt_val;
          alu_out <= pc + boff;
          state   <= dec_next;
          if (dec_next == S_HALT) halted <= 1'b1;
        end
        S_EXEC_R: begin
          alu_out <= r_res;
          if (r_ok) begin
            state <= S_WB_R;
          end else begin
            state  <= S_HALT;
            halted <= 1'b1;
          end
        end
        S_EXEC_I: begin
          alu_out <= ea;
          state   <= S_WB_I;
        end
        S_WB_R, S_WB_I, S_WB_MEM: begin
          state    <= S_FETCH;
          mem_read <= 1'b1;
          mem_addr <= pc[ADDR_W-1:0];
        end
        S_MEM_ADR: begin
          alu_out  <= ea;
          mem_addr <= ea[ADDR_W-1:0];
          if (op == OP_LW) begin
            mem_read <= 1'b1;
            state    <= S_MEM_RD;
          end else begin
            mem_write <= 1'b1;
            mem_wdata <= b;
            state     <= S_MEM_WR;
          end
        end
        S_MEM_RD: begin
          if (mem_ready) begin
            mdr      <= mem_rdata;
            mem_read <= 1'b0;
            state    <= S_WB_MEM;
          end
        end
        S_MEM_WR: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= pc[ADDR_W-1:0];
            state     <= S_FETCH;
          end
        end
        S_BRANCH: begin
          mem_read <= 1'b1;
          state    <= S_FETCH;
          if (br_take) begin
            pc       <= alu_out;
            mem_addr <= alu_out[ADDR_W-1:0];
          end else begin
            mem_addr <= pc[ADDR_W-1:0];
          end
        end
        S_JUMP: begin
          pc       <= jtgt;
          mem_addr <= jtgt[ADDR_W-1:0];
          mem_read <= 1'b1;
          state    <= S_FETCH;
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state  <= S_HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/mips_multi.md
Name: mips_multi

Overview:
Multicycle MIPS processor core. It executes the same integer subset as the single-cycle core, plus addi and a halt condition. It uses one shared instruction/data memory port with a ready handshake, so wait-state memories can be attached. It contains an internal register file and a control FSM, and drives the testbench and system memory directly.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, width of mem_addr; the low ADDR_W bits of the byte address are driven
RF_DEPTH, 32, register count; must be 32, other values are a synthesis error

Ports:
clk  in  1  core clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
mem_addr  out  ADDR_W  byte address for fetch, lw and sw
mem_wdata  out  32  store data
mem_rdata  in  32  read data; valid in the cycle mem_ready=1
mem_read  out  1  read request, held until accepted
mem_write  out  1  write request, held until accepted
mem_ready  in  1  memory completes the request in this cycle
pc_out  out  32  architectural PC
halted  out  1  core stopped on an unsupported opcode

Behaviour:
Reset (reset=0, asynchronous)
- pc=RESET_PC; FSM=FETCH; IR, MDR, A, B and ALUOut cleared to 0.
- mem_read=0, mem_write=0, halted=0, mem_addr=0, mem_wdata=0.
- Register file contents are not reset.
- Reset deasserted: mem_read rises in the first FETCH cycle, from registered FSM decode.
- Reset mid-access aborts the access immediately; no register or PC update occurs.

Memory handshake
- Outputs are registered and stable while a request is pending.
- mem_read and mem_write are never both 1.
- The FSM stays in a memory state while mem_ready=0; it advances on the edge where mem_ready=1.
- mem_ready while no request is pending is ignored.
- Zero wait states give the minimum latencies listed below.

FSM states and transitions
- FETCH: mem_addr=pc, mem_read=1. On ready: IR<=mem_rdata, pc<=pc+4 -> DECODE.
- DECODE: A<=RF[rs], B<=RF[rt], ALUOut<=pc+(sext(imm)<<2). Next state by opcode:
  - 000000 -> EXEC_R
  - 100011 or 101011 -> MEM_ADR
  - 001000 -> EXEC_I
  - 000100 or 000101 -> BRANCH
  - 000010 -> JUMP
  - any other opcode -> HALT
- EXEC_R: ALUOut<=A op B. funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed). Other funct -> HALT. Else -> WB_R.
- WB_R: RF[rd]<=ALUOut -> FETCH.
- EXEC_I: ALUOut<=A+sext(imm) -> WB_I.
- WB_I: RF[rt]<=ALUOut -> FETCH.
- MEM_ADR: ALUOut<=A+sext(imm) -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_addr=ALUOut, mem_read=1. On ready: MDR<=mem_rdata -> WB_MEM.
- WB_MEM: RF[rt]<=MDR -> FETCH.
- MEM_WR: mem_addr=ALUOut, mem_wdata=B, mem_write=1. On ready -> FETCH.
- BRANCH: beq taken if A==B; bne taken if A!=B. Taken: pc<=ALUOut. Always -> FETCH.
- JUMP: pc<={pc[31:28], IR[25:0], 2'b00} -> FETCH.
- HALT: halted=1, no memory requests, terminal until reset.

Arithmetic and register rules
- All ALU arithmetic is 32-bit wrap-around; no overflow trap.
- slt result is 1 or 0, zero-extended.
- Writes to register 0 are discarded; reads of register 0 return 0.
- Within DECODE, register file reads reflect all prior writebacks.

Latency at zero wait
- R-type 4 cycles, addi 4, lw 5, sw 4, beq/bne 3, j 3.
- Each wait cycle adds one cycle.
- Unaligned addresses are passed through unchanged; bits [1:0] are not checked.

Test Plan:
- Reset and first fetch: hold reset=0 three cycles, RESET_PC=0x40 -> pc_out=0x40, mem_read=0; after release mem_read=1 and mem_addr=0x40 next cycle.
- R-type and addi, zero wait: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 -> $3=2, $4=1, 16 cycles total; addi $0,$0,7 leaves $0=0.
- Load/store with waits: mem_ready delayed 2 cycles per access. sw $3,8($0) -> one write beat, addr 8, data 2. lw $5,8($0) -> $5=2. Request signals stay stable during waits.
- Branches and jump: beq $1,$1,+2 at 0x10 -> pc 0x1C. bne $1,$1,+2 -> pc 0x14. j 0x100 at 0x20 -> pc 0x400.
- Halt: opcode 111111 or funct 000000 in R-type -> halted=1, mem_read stays 0 for 20 cycles, pc frozen.
- Reset mid-access: assert reset during MEM_WR wait -> mem_write drops in the same cycle, no store recorded, restart at RESET_PC.
